matmul_req_arbiter: RTL and testbench
=====================================

Name: matmul_req_arbiter

Overview:
- Shares one matrix_mul 3x3 systolic engine between two independent requesters (port 0, port 1).
- Each job is one A/B operand pair; the result is one C matrix.
- Arbitrates issue slots round-robin and tracks job ownership in an in-order tag FIFO.
- Routes each engine result back to the requester that issued it.
- Sits between requester logic and matrix_mul: it drives en / in_Dvalid / din_A / din_B and consumes out_Dready / dout_C / out_vld.

Parameters:
- DATA_W, 8, operand element width; result elements are 2*DATA_W.
- TAG_DEPTH, 4, maximum outstanding jobs; depth of the tag FIFO; power of two, minimum 2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  block enable; forwarded to the engine
- req_valid  in  2  per-port job request
- req_ready  out  2  per-port accept
- req_a0  in  9*DATA_W  port 0 A operand, same packing as the engine
- req_b0  in  9*DATA_W  port 0 B operand, transposed
- req_a1  in  9*DATA_W  port 1 A operand
- req_b1  in  9*DATA_W  port 1 B operand
- res_valid  out  2  per-port one-cycle result pulse
- res_data  out  18*DATA_W  result C; shared by both ports; qualified by res_valid
- mm_en  out  1  to engine en
- mm_dvalid  out  1  to engine in_Dvalid
- mm_dready  in  1  from engine out_Dready
- mm_din_a  out  9*DATA_W  to engine din_A
- mm_din_b  out  9*DATA_W  to engine din_B
- mm_dout_c  in  18*DATA_W  from engine dout_C
- mm_out_vld  in  1  from engine out_vld
- outstanding  out  clog2(TAG_DEPTH)+1  jobs issued and not yet returned
- err_spurious  out  1  sticky; set when a result arrives with no outstanding job

Behaviour:
- Reset values:
  - req_ready=0, res_valid=0, res_data=0
  - mm_dvalid=0, mm_din_a=0, mm_din_b=0
  - outstanding=0, err_spurious=0
  - tag FIFO empty, round-robin pointer=0
  - mm_en = en (combinational pass-through)
- Issue condition: issue_ok = en & mm_dready & ~fifo_full.
- Grant (combinational):
  - Only one port requests: that port is granted if issue_ok.
  - Both request: the port equal to the rr pointer is granted.
  - req_ready[p] = grant[p].
  - A handshake occurs when req_valid[p] & req_ready[p].
- Issue path (zero latency):
  - mm_dvalid = |grant.
  - mm_din_a / mm_din_b = operands of the granted port; all zeros when there is no grant.
  - Requesters must hold payload stable while req_valid is high and req_ready is low.
- Round-robin pointer:
  - On any grant, rr <= ~granted_port.
  - Without a grant, rr holds.
  - A single requester is therefore never starved and never stalled by an idle peer.
- Tag FIFO:
  - Push the granted port id on issue.
  - Pop on mm_out_vld.
  - Results return strictly in issue order.
  - Simultaneous push and pop is allowed when full: count unchanged, issue permitted that cycle (fifo_full is evaluated as full & ~pop).
  - Pointers wrap modulo TAG_DEPTH.
- Result return (1-cycle registered latency):
  - On mm_out_vld with FIFO non-empty: next cycle res_data <= mm_dout_c and res_valid[tag] <= 1.
  - res_valid is a single-cycle pulse.
  - res_data holds its last value otherwise.
  - No backpressure exists on the result side; requesters must sample on the pulse.
- Spurious result: mm_out_vld with FIFO empty and no same-cycle push.
  - Set err_spurious; drop the data; res_valid stays 0.
  - err_spurious clears only on reset.
- outstanding equals the FIFO occupancy, updated the same cycle as push/pop.
- en low:
  - No grants (req_ready=0, mm_dvalid=0).
  - The engine internal counter is cleared by its own en.
  - Tag FIFO is flushed at the next edge (outstanding->0).
  - A mm_out_vld arriving while en is low is ignored and not flagged.
- Reset mid-operation: all state returns to the reset values immediately (asynchronous); in-flight jobs are lost with no result pulse.
- Arithmetic: no computation here; widths pass through unchanged.

Decomposition:
- Shared package:
  - ROW/COL/NUM = 3
  - operand width 9*DATA_W and result width 18*DATA_W as localparams
  - requester id type (1 bit)
  - NUM_REQ = 2
- Sub-module mm_tag_fifo: synchronous FIFO of 1-bit ids, TAG_DEPTH entries, with push/pop/full/empty/count and flush.
- Arbiter, result register and error flag stay in the top.

Test Plan (all cases use DATA_W=8):
- Single port: port 0 issues A=identity, B=all 2s.
  - Exactly one res_valid[0] pulse, every C element = 16'h0002.
  - res_valid[1] stays 0.
- Contention: both ports valid continuously.
  - Grants alternate 0,1,0,1.
  - Four results route to res_valid 0,1,0,1 in order.
  - Port 0 data = A0×B0 and port 1 data = A1×B1 (A1 all 1s, B1 all 3s gives C = 16'h0009).
- Full FIFO: TAG_DEPTH=2, engine results withheld by a stub.
  - After 2 issues, req_ready=0 and outstanding=2.
  - Stub asserts mm_out_vld with mm_dready high in the same cycle: a third issue is accepted and outstanding stays 2.
- Spurious: stub pulses mm_out_vld with outstanding=0.
  - err_spurious=1 from the next cycle and stays high.
  - No res_valid pulse.
- en drop: en deasserted with 2 jobs outstanding.
  - req_ready=0 and outstanding=0 at the next edge.
  - A late mm_out_vld produces no res_valid and no error.
- Async reset: assert rst_n low mid-issue.
  - All outputs go to zero within the same cycle.
  - After release the first grant goes to port 0.

Source files
------------

// File: rtl/matmul_req_arbiter_pkg.sv
// Shared constants and types for the two-port matmul request arbiter.
// Widths are expressed per DATA_W so every file sizes buses the same way.
package matmul_req_arbiter_pkg;
  localparam int ROW     = 3;
  localparam int COL     = 3;
  localparam int NUM     = 3;
  localparam int ELEMS   = ROW * COL;
  localparam int NUM_REQ = 2;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_OPND_W = ELEMS * DEF_DATA_W;
  localparam int DEF_RES_W  = 2 * ELEMS * DEF_DATA_W;

  typedef logic req_id_t;

  function automatic int opnd_w(input int data_w);
    return ELEMS * data_w;
  endfunction

  function automatic int res_w(input int data_w);
    return 2 * ELEMS * data_w;
  endfunction
endpackage

// File: rtl/matmul_req_arbiter_if.sv
// Requester-side bus: two job request ports and the shared result return.
// The arbiter takes the slave view, requester logic the master view.
interface matmul_req_arbiter_if #(parameter int DATA_W = 8);
  import matmul_req_arbiter_pkg::*;

  logic [NUM_REQ-1:0]              req_valid;
  logic [NUM_REQ-1:0]              req_ready;
  logic [opnd_w(DATA_W)-1:0]       req_a0;
  logic [opnd_w(DATA_W)-1:0]       req_b0;
  logic [opnd_w(DATA_W)-1:0]       req_a1;
  logic [opnd_w(DATA_W)-1:0]       req_b1;
  logic [NUM_REQ-1:0]              res_valid;
  logic [res_w(DATA_W)-1:0]        res_data;

  modport slave (
    input  req_valid, req_a0, req_b0, req_a1, req_b1,
    output req_ready, res_valid, res_data
  );

  modport master (
    output req_valid, req_a0, req_b0, req_a1, req_b1,
    input  req_ready, res_valid, res_data
  );
endinterface

// File: rtl/matmul_req_arbiter_tag_fifo.sv
// In-order FIFO of requester ids for jobs in flight in the engine.
// flush drops every entry at the next edge without touching storage.
module mm_tag_fifo
  import matmul_req_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  req_id_t                    din,
  output req_id_t                    dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DEPTH-1:0] mem;
  logic [AW-1:0]    wptr, rptr;
  logic [CW-1:0]    cnt;
  logic             wr, rd;

  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;
  assign dout  = mem[rptr];

  // A push into a full FIFO is legal when the head leaves in the same cycle.
  assign wr = push & (~full | pop);
  assign rd = pop & ~empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem  <= '0;
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (wr) begin
        mem[wptr] <= din;
        wptr      <= wptr + 1'b1;
      end
      if (rd) rptr <= rptr + 1'b1;
      cnt <= cnt + {{AW{1'b0}}, wr} - {{AW{1'b0}}, rd};
    end
  end
endmodule

// File: rtl/matmul_req_arbiter.sv
// Shares one 3x3 systolic matmul engine between two requesters: round-robin
// issue, in-order ownership tags, and registered routing of each result.
module matmul_req_arbiter
  import matmul_req_arbiter_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int TAG_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  matmul_req_arbiter_if.slave           req,
  output logic                          mm_en,
  output logic                          mm_dvalid,
  input  logic                          mm_dready,
  output logic [opnd_w(DATA_W)-1:0]     mm_din_a,
  output logic [opnd_w(DATA_W)-1:0]     mm_din_b,
  input  logic [res_w(DATA_W)-1:0]      mm_dout_c,
  input  logic                          mm_out_vld,
  output logic [$clog2(TAG_DEPTH):0]    outstanding,
  output logic                          err_spurious
);
  localparam int OPW  = opnd_w(DATA_W);
  localparam int RESW = res_w(DATA_W);

  logic               full, empty, push, pop, fifo_full, issue_ok, rr, spurious;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] res_vld_q;
  logic [RESW-1:0]    res_data_q;
  req_id_t            gnt_id, tag;

  assign mm_en = en;

  assign pop       = en & mm_out_vld & ~empty;
  assign fifo_full = full & ~pop;
  // rst_n in the issue term keeps req_ready low for the whole reset window.
  assign issue_ok  = rst_n & en & mm_dready & ~fifo_full;

  always_comb begin
    grant = '0;
    if (issue_ok) begin
      unique case (req.req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = rr ? 2'b10 : 2'b01;
        default: grant = '0;
      endcase
    end
  end

  assign gnt_id        = grant[1];
  assign push          = |grant;
  assign req.req_ready = grant;
  assign mm_dvalid     = push;

  always_comb begin
    mm_din_a = '0;
    mm_din_b = '0;
    if (grant[0]) begin
      mm_din_a = req.req_a0;
      mm_din_b = req.req_b0;
    end else if (grant[1]) begin
      mm_din_a = req.req_a1;
      mm_din_b = req.req_b1;
    end
  end

  // A same-cycle issue means the engine is not idle, so no error is raised.
  assign spurious = en & mm_out_vld & empty & ~push;

  mm_tag_fifo #(.DEPTH(TAG_DEPTH)) u_tag_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (~en),
    .push  (push),
    .pop   (pop),
    .din   (gnt_id),
    .dout  (tag),
    .full  (full),
    .empty (empty),
    .count (outstanding)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr           <= 1'b0;
      res_vld_q    <= '0;
      res_data_q   <= '0;
      err_spurious <= 1'b0;
    end else begin
      if (push) rr <= ~gnt_id;
      res_vld_q <= '0;
      if (pop) begin
        res_vld_q  <= tag ? 2'b10 : 2'b01;
        res_data_q <= mm_dout_c;
      end
      if (spurious) err_spurious <= 1'b1;
    end
  end

  assign req.res_valid = res_vld_q;
  assign req.res_data  = res_data_q;

  logic unused_ok;
  assign unused_ok = &{1'b0, OPW[0]};
endmodule

// File: tb/tb_matmul_req_arbiter.sv
// Random and directed stimulus for the matmul arbiter against a queue-based
// job model; a behavioural engine stub computes products and returns them.
`timescale 1ns/1ps
module tb_matmul_req_arbiter;
  import matmul_req_arbiter_pkg::*;

  localparam int DW   = 8;
  localparam int TD   = 2;
  localparam int OPW  = 9 * DW;
  localparam int RESW = 18 * DW;
  localparam int CW   = $clog2(TD) + 1;
  localparam int LAT  = 3;

  logic            clk = 1'b0, rst_n = 1'b0, en = 1'b0;
  logic            mm_en, mm_dvalid, mm_dready, mm_out_vld, err_spurious;
  logic [OPW-1:0]  mm_din_a, mm_din_b;
  logic [RESW-1:0] mm_dout_c;
  logic [CW-1:0]   outstanding;

  matmul_req_arbiter_if #(.DATA_W(DW)) bus();

  matmul_req_arbiter #(.DATA_W(DW), .TAG_DEPTH(TD)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req(bus),
    .mm_en(mm_en), .mm_dvalid(mm_dvalid), .mm_dready(mm_dready),
    .mm_din_a(mm_din_a), .mm_din_b(mm_din_b), .mm_dout_c(mm_dout_c),
    .mm_out_vld(mm_out_vld), .outstanding(outstanding), .err_spurious(err_spurious)
  );

  always #5 clk = ~clk;

  typedef struct { logic port; logic [RESW-1:0] c; } job_t;
  typedef struct { logic [RESW-1:0] c; int due; } eng_t;

  int   total = 0, bad = 0;
  job_t mq[$], exp_q[$], rlog[$];
  logic glog[$];
  eng_t eq[$];
  logic m_rr = 1'b0, m_err = 1'b0;
  logic [1:0] hs = '0;
  int   mode[2];
  logic fixed_ops = 1'b0, drop_req = 1'b0;
  logic [OPW-1:0] fa[2], fb[2];
  logic auto_ret = 1'b1, rel_req = 1'b0, spur_req = 1'b0, dready_rand = 1'b0, vld_from_q = 1'b0;
  int   cyc = 0;

  function automatic logic [RESW-1:0] mat_mul(input logic [OPW-1:0] a, input logic [OPW-1:0] b);
    logic [RESW-1:0] c;
    int unsigned s;
    c = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        s = 0;
        for (int k = 0; k < 3; k++) s += a[(i*3+k)*DW +: DW] * b[(j*3+k)*DW +: DW];
        c[(i*3+j)*2*DW +: 2*DW] = s[2*DW-1:0];
      end
    return c;
  endfunction

  function automatic logic [OPW-1:0] fill(input logic [DW-1:0] v);
    logic [OPW-1:0] r;
    for (int e = 0; e < 9; e++) r[e*DW +: DW] = v;
    return r;
  endfunction

  function automatic logic [RESW-1:0] fill_c(input logic [2*DW-1:0] v);
    logic [RESW-1:0] r;
    for (int e = 0; e < 9; e++) r[e*2*DW +: 2*DW] = v;
    return r;
  endfunction

  function automatic logic [OPW-1:0] ident();
    logic [OPW-1:0] r;
    r = '0;
    for (int i = 0; i < 3; i++) r[(i*4)*DW +: DW] = DW'(1);
    return r;
  endfunction

  function automatic logic [OPW-1:0] rand_op();
    logic [OPW-1:0] r;
    for (int e = 0; e < 9; e++) r[e*DW +: DW] = DW'($urandom);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [RESW-1:0] act, input logic [RESW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    total++;
    bad++;
    $display("FAIL %s: wait bound expired", nm);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while ((mq.size() > 0 || exp_q.size() > 0 || bus.req_valid != 0) && n < 300) begin
      tick(1);
      n++;
    end
    if (n >= 300) timeout(nm);
  endtask

  // Monitor: checks outputs against the job model, then advances the model
  // with what the coming edge will do.
  always @(negedge clk) begin : mon
    logic [1:0] eg;
    logic pop, push, spur;
    job_t j;
    chk("mm_en", mm_en, en);
    if (!rst_n) begin
      chk("rst req_ready", bus.req_ready, 0);
      chk("rst res_valid", bus.res_valid, 0);
      chk("rst res_data", bus.res_data, 0);
      chk("rst mm_dvalid", mm_dvalid, 0);
      chk("rst mm_din_a", mm_din_a, 0);
      chk("rst mm_din_b", mm_din_b, 0);
      chk("rst outstanding", outstanding, 0);
      chk("rst err", err_spurious, 0);
      mq.delete(); exp_q.delete();
      m_rr = 1'b0; m_err = 1'b0; hs = '0;
    end else begin
      if (bus.res_valid != 0) rlog.push_back(job_t'{bus.res_valid[1], bus.res_data});
      if (exp_q.size() > 0) begin
        j = exp_q.pop_front();
        chk("res_valid", bus.res_valid, j.port ? 2'b10 : 2'b01);
        chk("res_data", bus.res_data, j.c);
      end else chk("res_valid idle", bus.res_valid, 0);
      chk("outstanding", outstanding, mq.size());
      chk("err_spurious", err_spurious, m_err);

      pop = en && mm_out_vld && mq.size() > 0;
      eg  = '0;
      if (en && mm_dready && !(mq.size() == TD && !pop))
        eg = (bus.req_valid == 2'b11) ? (m_rr ? 2'b10 : 2'b01) : bus.req_valid;
      chk("req_ready", bus.req_ready, eg);
      chk("mm_dvalid", mm_dvalid, |eg);
      chk("mm_din_a", mm_din_a, eg[0] ? bus.req_a0 : (eg[1] ? bus.req_a1 : '0));
      chk("mm_din_b", mm_din_b, eg[0] ? bus.req_b0 : (eg[1] ? bus.req_b1 : '0));
      push = |eg;
      spur = en && mm_out_vld && mq.size() == 0 && !push;
      hs = bus.req_valid & bus.req_ready;
      if (bus.req_ready != 0) glog.push_back(bus.req_ready[1]);

      if (!en) mq.delete();
      else begin
        if (pop) exp_q.push_back(mq.pop_front());
        if (spur) m_err = 1'b1;
        if (push) begin
          mq.push_back(job_t'{eg[1], eg[1] ? mat_mul(bus.req_a1, bus.req_b1)
                                           : mat_mul(bus.req_a0, bus.req_b0)});
          m_rr = ~eg[1];
        end
      end
    end
  end

  // Engine stub: fixed-latency products, or held until released one by one.
  initial begin : stub
    mm_out_vld = 1'b0; mm_dout_c = '0; mm_dready = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst_n || !en) eq.delete();
      else begin
        if (mm_out_vld && vld_from_q && eq.size() > 0) eq.delete(0);
        if (mm_dvalid && mm_dready) eq.push_back(eng_t'{mat_mul(mm_din_a, mm_din_b), cyc + LAT});
      end
      @(posedge clk); #1;
      cyc++;
      mm_out_vld = 1'b0; vld_from_q = 1'b0;
      if (spur_req) begin
        mm_out_vld = 1'b1;
        for (int e = 0; e < 9; e++) mm_dout_c[e*2*DW +: 2*DW] = (2*DW)'($urandom);
        spur_req = 1'b0;
      end else if (eq.size() > 0 && (auto_ret ? (eq[0].due <= cyc) : rel_req)) begin
        mm_out_vld = 1'b1; vld_from_q = 1'b1;
        mm_dout_c  = eq[0].c;
        rel_req    = 1'b0;
      end
      mm_dready = dready_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // Requesters: payload held until the handshake, then a new job per mode
  // (0 idle, 1 back-to-back, 2 random, 3 one job then idle).
  initial begin : drv
    bus.req_valid = '0;
    bus.req_a0 = '0; bus.req_b0 = '0; bus.req_a1 = '0; bus.req_b1 = '0;
    forever begin
      @(posedge clk); #1;
      if (drop_req) begin bus.req_valid = '0; drop_req = 1'b0; end
      for (int p = 0; p < 2; p++) begin
        if (bus.req_valid[p] && hs[p]) bus.req_valid[p] = 1'b0;
        if (!bus.req_valid[p] &&
            (mode[p] == 1 || mode[p] == 3 || (mode[p] == 2 && $urandom_range(0, 1) == 1))) begin
          if (p == 0) begin
            bus.req_a0 = fixed_ops ? fa[0] : rand_op();
            bus.req_b0 = fixed_ops ? fb[0] : rand_op();
          end else begin
            bus.req_a1 = fixed_ops ? fa[1] : rand_op();
            bus.req_b1 = fixed_ops ? fb[1] : rand_op();
          end
          bus.req_valid[p] = 1'b1;
          if (mode[p] == 3) mode[p] = 0;
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int n, r0;
    mode[0] = 0; mode[1] = 0;
    fa[0] = ident(); fb[0] = fill(8'd2);
    fa[1] = fill(8'd1); fb[1] = fill(8'd3);
    repeat (3) @(posedge clk);
    #2; rst_n = 1'b1; en = 1'b1;
    tick(1);

    // contention: both ports back-to-back from a fresh round-robin state
    fixed_ops = 1'b1; glog.delete(); rlog.delete();
    mode[0] = 1; mode[1] = 1;
    n = 0;
    while (glog.size() < 4 && n < 100) begin tick(1); n++; end
    if (n >= 100) timeout("cont grants");
    mode[0] = 0; mode[1] = 0; drop_req = 1'b1;
    wait_idle("cont drain");
    if (glog.size() >= 4 && rlog.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("cont grant", glog[i], i % 2);
        chk("cont route", rlog[i].port, i % 2);
        chk("cont data", rlog[i].c, (i % 2) ? fill_c(16'h0009) : fill_c(16'h0002));
      end
    end else timeout("cont logs");

    // single port 0 job
    rlog.delete();
    mode[0] = 3;
    tick(2);
    wait_idle("single drain");
    chk("single count", rlog.size(), 1);
    if (rlog.size() > 0) begin
      chk("single port", rlog[0].port, 0);
      chk("single data", rlog[0].c, fill_c(16'h0002));
    end

    // full FIFO with results withheld, then a same-cycle pop/push
    fixed_ops = 1'b0; auto_ret = 1'b0;
    mode[0] = 1; mode[1] = 1;
    n = 0;
    while (outstanding != CW'(TD) && n < 50) begin tick(1); n++; end
    if (n >= 50) timeout("full fill");
    @(negedge clk);
    chk("full req_ready", bus.req_ready, 0);
    chk("full outstanding", outstanding, TD);
    rel_req = 1'b1;
    @(negedge clk);
    chk("full pop issue", bus.req_ready != 0, 1);
    @(negedge clk);
    chk("full outstanding held", outstanding, TD);
    #2;
    mode[0] = 0; mode[1] = 0; drop_req = 1'b1; auto_ret = 1'b1;
    wait_idle("full drain");

    // en drop with two jobs in flight, then a late engine result
    auto_ret = 1'b0; mode[0] = 1;
    n = 0;
    while (outstanding != CW'(TD) && n < 50) begin tick(1); n++; end
    if (n >= 50) timeout("en fill");
    en = 1'b0;
    @(negedge clk);
    chk("en req_ready", bus.req_ready, 0);
    @(negedge clk);
    chk("en outstanding", outstanding, 0);
    r0 = rlog.size();
    spur_req = 1'b1;
    @(negedge clk); @(negedge clk); @(negedge clk);
    chk("en late no pulse", rlog.size(), r0);
    chk("en late no err", err_spurious, 0);
    #2;
    mode[0] = 0; drop_req = 1'b1; auto_ret = 1'b1;
    tick(1);
    en = 1'b1;
    wait_idle("en drain");

    // spurious result with nothing outstanding
    r0 = rlog.size();
    spur_req = 1'b1;
    tick(3);
    chk("spur err", err_spurious, 1);
    chk("spur no pulse", rlog.size(), r0);
    tick(5);
    chk("spur sticky", err_spurious, 1);

    // random soak with engine stalls and occasional en drops
    mode[0] = 2; mode[1] = 2; dready_rand = 1'b1;
    repeat (500) begin
      en = ($urandom_range(0, 40) != 0);
      tick(1);
    end
    en = 1'b1; mode[0] = 0; mode[1] = 0; drop_req = 1'b1; dready_rand = 1'b0;
    wait_idle("soak drain");

    // async reset in the middle of issuing
    mode[0] = 1; mode[1] = 1;
    tick(5);
    rst_n = 1'b0;
    #1;
    chk("arst req_ready", bus.req_ready, 0);
    chk("arst mm_dvalid", mm_dvalid, 0);
    chk("arst outstanding", outstanding, 0);
    chk("arst err", err_spurious, 0);
    chk("arst res_valid", bus.res_valid, 0);
    tick(2);
    glog.delete();
    rst_n = 1'b1;
    n = 0;
    while (glog.size() == 0 && n < 20) begin tick(1); n++; end
    if (n >= 20) timeout("arst grant");
    else chk("arst first grant", glog[0], 0);
    mode[0] = 0; mode[1] = 0; drop_req = 1'b1;
    wait_idle("final drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
